// File: rtl/mem_store_buffer_if.sv
// Store-buffer bus bundle: M-stage store/load requests and the data-memory write port.
// master = pipeline/memory side driving requests, slave = the buffer itself.
interface mem_store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]     st_type;
  logic [31:0]    st_addr;
  logic [31:0]    st_data;
  logic [31:0]    st_pc;
  logic           st_ready;
  logic           st_err;
  logic           ld_valid;
  logic [31:0]    ld_addr;
  logic           ld_stall;
  logic           dm_we;
  logic           dm_ready;
  logic [31:0]    dm_addr;
  logic [3:0]     dm_be;
  logic [31:0]    dm_wdata;
  logic [31:0]    dm_pc;
  logic [PTR_W:0] count;

  modport master (
    output st_type, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_ready,
    input  st_ready, st_err, ld_stall, dm_we, dm_addr, dm_be, dm_wdata, dm_pc, count
  );

  modport slave (
    input  st_type, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_ready,
    output st_ready, st_err, ld_stall, dm_we, dm_addr, dm_be, dm_wdata, dm_pc, count
  );
endinterface

// File: rtl/mem_store_buffer.sv
// In-order store buffer between M-stage and data memory, with load-hazard stall.
// Optional STORE_TRACE_EN prints one trace line per store written to memory.
module mem_store_buffer #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  mem_store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [29:0]      addrMem [DEPTH];
  logic [3:0]       beMem   [DEPTH];
  logic [31:0]      dataMem [DEPTH];
  logic [31:0]      pcMem   [DEPTH];
  logic [DEPTH-1:0] validReg;
  logic [PTR_W-1:0] headReg;
  logic [PTR_W-1:0] tailReg;
  logic [PTR_W:0]   countReg;
  logic             stErrReg;

  logic [3:0]       reqBe;
  logic [31:0]      reqData;
  logic             reqMisaligned;
  logic             full;
  logic             hasHead;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] hit;
  logic             unusedLdLow;

  always_comb begin
    reqBe         = 4'b0000;
    reqData       = bus.st_data;
    reqMisaligned = 1'b0;
    case (bus.st_type)
      2'd1: begin
        reqBe         = 4'b1111;
        reqMisaligned = (bus.st_addr[1:0] != 2'b00);
      end
      2'd2: begin
        reqBe         = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        reqData       = {2{bus.st_data[15:0]}};
        reqMisaligned = bus.st_addr[0];
      end
      2'd3: begin
        reqBe   = 4'b0001 << bus.st_addr[1:0];
        reqData = {4{bus.st_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign full    = (countReg == FULL_COUNT);
  assign hasHead = (countReg != '0);
  // No push-through: a full buffer refuses even when it pops this cycle.
  assign push    = (bus.st_type != 2'd0) && !full && !reqMisaligned;
  assign pop     = bus.dm_we && bus.dm_ready;

  assign bus.st_ready = !full;
  assign bus.st_err   = stErrReg;
  assign bus.count    = countReg;
  assign bus.dm_we    = hasHead && !reset;
  assign bus.dm_addr  = hasHead ? {addrMem[headReg], 2'b00} : 32'd0;
  assign bus.dm_be    = hasHead ? beMem[headReg] : 4'b0000;
  assign bus.dm_wdata = hasHead ? dataMem[headReg] : 32'd0;
  assign bus.dm_pc    = hasHead ? pcMem[headReg] : 32'd0;

  // Hazard compares registered entries only; the entry popping this cycle still hits.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gHit
      assign hit[gi] = validReg[gi] && (addrMem[gi] == bus.ld_addr[31:2]);
    end
  endgenerate
  assign bus.ld_stall = bus.ld_valid && (|hit);
  assign unusedLdLow  = ^bus.ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
      validReg <= '0;
      stErrReg <= 1'b0;
    end else begin
      stErrReg <= (bus.st_type != 2'd0) && reqMisaligned;
      if (push) begin
        validReg[tailReg] <= 1'b1;
        tailReg           <= tailReg + PTR_W'(1);
      end
      if (pop) begin
        validReg[headReg] <= 1'b0;
        headReg           <= headReg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   countReg <= countReg + (PTR_W+1)'(1);
        2'b01:   countReg <= countReg - (PTR_W+1)'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[tailReg] <= bus.st_addr[31:2];
      beMem[tailReg]   <= reqBe;
      dataMem[tailReg] <= reqData;
      pcMem[tailReg]   <= bus.st_pc;
    end
  end

`ifdef STORE_TRACE_EN
  logic [1:0] lowLane;
  always_comb begin
    lowLane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.dm_be[i]) lowLane = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && pop) begin
      $display("@%h: *%h <= %h", bus.dm_pc, bus.dm_addr | {30'd0, lowLane}, bus.dm_wdata);
    end
  end
`else
  // Trace disabled: the buffer is silent in simulation.
`endif
endmodule
